// File: rtl/frame_sequencer.sv
// frame_sequencer
// Rotates NUM_BUF frame buffers through three roles: displayed (disp_buf),
// completed-and-queued (pending of them), and being built (draw_buf). It
// sequences the clear and line-drawing engines with start/done pulses, and
// swaps the displayed buffer only on an active vsync edge. A vsync edge with
// nothing queued repeats the old frame and is counted as a drop.
//
// Ports
//   clk, reset   system clock, asynchronous active-high reset
//   vsync        raw vertical sync, asynchronous to clk
//   clr_done     clear engine finished draw_buf (1-cycle pulse)
//   draw_done    draw engine finished the frame (1-cycle pulse)
//   clr_start    start clearing draw_buf (1-cycle pulse)
//   draw_start   start drawing into draw_buf (1-cycle pulse)
//   select       write-port mux: 1 = clear engine, 0 = draw engine
//   disp_buf     buffer index scanned out by video
//   draw_buf     buffer index being cleared/drawn
//   pending      completed buffers not yet displayed
//   frame_drop   vsync edge with no completed frame (1-cycle pulse)
//   drop_cnt     saturating count of frame_drop pulses
//
// state | meaning
// IDLE  | queue full, waiting for a free buffer
// CLEAR | clear engine owns draw_buf
// DRAW  | draw engine owns draw_buf
module frame_sequencer #(
  parameter int NUM_BUF    = 2,
  parameter int BUF_W      = 3,
  parameter int VS_ACT_LOW = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync,
  input  logic             clr_done,
  input  logic             draw_done,
  output logic             clr_start,
  output logic             draw_start,
  output logic             select,
  output logic [BUF_W-1:0] disp_buf,
  output logic [BUF_W-1:0] draw_buf,
  output logic [BUF_W-1:0] pending,
  output logic             frame_drop,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW} state_t;

  localparam logic           VS_IDLE = (VS_ACT_LOW != 0);
  localparam logic [BUF_W:0] NB      = (BUF_W+1)'(NUM_BUF);
  localparam logic [BUF_W:0] ONE     = (BUF_W+1)'(1);

  // Index sums never exceed 2*NUM_BUF-1, so one conditional subtract wraps.
  function automatic logic [BUF_W-1:0] wrap(input logic [BUF_W:0] v);
    logic [BUF_W:0] r;
    r = (v >= NB) ? (v - NB) : v;
    return r[BUF_W-1:0];
  endfunction

  state_t           state, state_n;
  logic             vs_s1, vs_s2, vs_s3;
  logic             vs_edge;
  logic             done_draw;
  logic [BUF_W:0]   pend_w;
  logic [BUF_W-1:0] disp_n, draw_n, pend_n;
  logic             clr_n, dstart_n, sel_n, drop_n;
  logic [CNT_W-1:0] cnt_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_s1 <= VS_IDLE;
      vs_s2 <= VS_IDLE;
      vs_s3 <= VS_IDLE;
    end else begin
      vs_s1 <= vsync;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
    end
  end

  assign vs_edge = (vs_s2 != VS_IDLE) && (vs_s3 == VS_IDLE);

  always_comb begin
    state_n   = state;
    disp_n    = disp_buf;
    drop_n    = 1'b0;
    cnt_n     = drop_cnt;
    done_draw = (state == DRAW) && draw_done;

    // A frame finishing on the swap cycle is counted before the swap, so it
    // can be shown immediately instead of being reported as a drop.
    pend_w = {1'b0, pending} + {{BUF_W{1'b0}}, done_draw};

    if (vs_edge) begin
      if (pend_w != '0) begin
        disp_n = wrap({1'b0, disp_buf} + ONE);
        pend_w = pend_w - ONE;
      end else begin
        drop_n = 1'b1;
        if (drop_cnt != '1) cnt_n = drop_cnt + CNT_W'(1);
      end
    end

    case (state)
      IDLE:    if (({1'b0, pending} + ONE) < NB) state_n = CLEAR;
      CLEAR:   if (clr_done) state_n = DRAW;
      DRAW:    if (draw_done) state_n = ((pend_w + ONE) < NB) ? CLEAR : IDLE;
      default: state_n = IDLE;
    endcase

    pend_n   = pend_w[BUF_W-1:0];
    draw_n   = wrap({1'b0, disp_n} + pend_w + ONE);
    clr_n    = (state_n == CLEAR) && (state != CLEAR);
    dstart_n = (state_n == DRAW) && (state != DRAW);
    sel_n    = (state_n == CLEAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      disp_buf   <= '0;
      pending    <= '0;
      draw_buf   <= BUF_W'(1);
      select     <= 1'b0;
      clr_start  <= 1'b0;
      draw_start <= 1'b0;
      frame_drop <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_n;
      disp_buf   <= disp_n;
      pending    <= pend_n;
      draw_buf   <= draw_n;
      select     <= sel_n;
      clr_start  <= clr_n;
      draw_start <= dstart_n;
      frame_drop <= drop_n;
      drop_cnt   <= cnt_n;
    end
  end

endmodule
